matriz_teclado_scan_rx: RTL and testbench
=========================================

// Module: matriz_teclado_scan_rx
// PURPOSE
//  Reader side of the column-scan matrix interface: drives a key-matrix column one-hot (active-low),
//  samples the row inputs, debounces and emits a 3-bit line/column coordinate for a single pressed key.
//  Sits between the player keypad and the attack/position register load logic; its key_lin/key_col
//  values index the same 7-row x 8-column grid the LED matrix driver displays.
// PARAMETERS
//  N_COL      8    columns driven (key_col range 0..N_COL-1)
//  N_LIN      7    row inputs sampled (key_lin range 0..N_LIN-1)
//  SCAN_DIV   1000 clk cycles each column is held before advancing (>=2)
//  DEB_SCANS  4    consecutive identical full-scan results required to accept a change (>=1)
// PORTS
//  clk        in   1      system clock; one clock, all state on rising edge
//  clr_n      in   1      reset, asynchronous, active-low
//  scan_en    in   1      1 = scan running; 0 = idle, columns released
//  k_col      out  N_COL  column drive, active-low one-hot; all-1 = none driven
//  k_line     in   N_LIN  row sense, active-low (0 = key at driven column pressed)
//  key_lin    out  3      row index of accepted key
//  key_col    out  3      column index of accepted key
//  key_valid  out  1      coordinate pending; held until key_ack
//  key_ack    in   1      consumer takes coordinate; valid&ack in same cycle = transfer
//  key_ovf    out  1      sticky: accepted key dropped because previous still pending
// BEHAVIOUR
//  Reset (clr_n=0, async): k_col=all-1, key_valid=0, key_lin=0, key_col=0, key_ovf=0, FSM=IDLE,
//   column index=0, dwell counter=0, debounce history cleared, released flag=1.
//  FSM: IDLE -> SCAN when scan_en=1. SCAN: k_col[idx]=0, others 1; dwell counter 0..SCAN_DIV-1;
//   k_line sampled only on dwell count SCAN_DIV-1 (settle); then idx++. After idx=N_COL-1 -> EVAL.
//   EVAL (1 cycle): classify scan: exactly one active bit overall -> candidate {lin,col}; zero -> NONE;
//   two or more -> NONE (ambiguous, ignored); idx=0, -> SCAN (or IDLE if scan_en=0).
//  scan_en=0 in SCAN/EVAL: abort next cycle -> IDLE, k_col=all-1, partial scan and debounce history
//   discarded; pending key_valid/key_lin/key_col retained.
//  Debounce: candidate equal to previous scan increments match count (saturating at DEB_SCANS),
//   different resets it to 1. At match count==DEB_SCANS: NONE sets released=1; a key with
//   released=1 is accepted and clears released. Same key held never re-accepted.
//  Accept: if key_valid=0, or key_ack=1 in the same cycle: load key_lin/key_col, key_valid=1.
//   Else drop, key_ovf=1 (cleared only by clr_n). key_ack with key_valid=0 ignored.
//  key_valid falls the cycle after valid&ack unless a new accept coincides.
//  Latency: stable press -> key_valid = DEB_SCANS full scans (N_COL*SCAN_DIV+1 cycles each) + 1 clk.
//  Widths: idx wraps N_COL-1 -> 0; dwell counter sized $clog2(SCAN_DIV); no other arithmetic.
// CONFIGURATION
//  KEY_REPEAT_EN defined: key still held as the sole key for 8*DEB_SCANS further scans after accept
//   is re-accepted, then every 2*DEB_SCANS scans while held; release stops repeat.
//  KEY_REPEAT_EN undefined: one accept per press; repeat counter not synthesised.
// STRUCTURE
//  Package matriz_teclado_pkg: FSM state encoding (IDLE/SCAN/EVAL), key code {lin[2:0],col[2:0]},
//   NONE code, coordinate widths shared with the matrix display path.
//  Sub-module matriz_teclado_debounce: candidate/match-count/released logic and repeat counter;
//   top holds FSM, column drive, row sampling, output handshake.
// TESTING (SCAN_DIV=4, DEB_SCANS=2; full scan = 33 clk)
//  Reset: clr_n=0 mid-scan -> k_col=8'hFF, key_valid=0, key_ovf=0 immediately (async).
//  Press row 2/col 5 (k_line[2]=0 while k_col[5]=0) for 3 scans -> key_valid=1, key_lin=2,
//   key_col=5 after 2nd scan's EVAL+1; ack -> key_valid=0 next clk; no re-accept while held.
//  Bounce: key toggles every scan for 6 scans, then stable -> exactly one accept, after 2 stable scans.
//  Two keys (1/0 and 4/7) pressed together -> no accept; release 4/7 -> 1/0 accepted after 2 scans.
//  No ack, press/release/press 3/3 -> first kept (lin=col=3 of first), key_ovf=1; ack and
//   new accept same cycle -> key_valid stays 1, key_ovf unaffected.
//  scan_en=0 mid-column 4 -> k_col=8'hFF next clk, FSM IDLE; re-enable -> scan restarts at column 0.

Source files
------------

// File: rtl/matriz_teclado_pkg.sv
`default_nettype none
// ============================================================================
// matriz_teclado_pkg : shared key-matrix types (scan FSM states, key code)
// Rev 1.0
// ============================================================================
package matriz_teclado_pkg;

    localparam int COORD_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] lin;
        logic [COORD_W-1:0] col;
    } key_code_t;

    // Row 7 does not exist on the 7-row grid, so 7/7 is free to mean "no key"
    localparam key_code_t KEY_NONE = key_code_t'(6'h3F);

    function automatic logic [1:0] hit_sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd2) ? 2'd2 : s[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matriz_teclado_debounce.sv
`default_nettype none
// ============================================================================
// matriz_teclado_debounce : scan-to-scan candidate filter, release tracking and
// optional auto-repeat (KEY_REPEAT_EN).
// Rev 1.0
// ============================================================================
module matriz_teclado_debounce
    import matriz_teclado_pkg::*;
#(
    parameter int DEB_SCANS = 4
) (
    input  logic      clk,
    input  logic      clr_n,
    input  logic      stb_i,
    input  logic      flush_i,
    input  key_code_t cand_i,
    output logic      accept_o
);

    localparam int              MW         = $clog2(DEB_SCANS + 1);
    localparam logic [MW-1:0]   MATCH_FULL = MW'(DEB_SCANS);

    key_code_t       prev_q, prev_d;
    logic [MW-1:0]   match_q, match_d;
    logic            rel_q, rel_d;

`ifdef KEY_REPEAT_EN
    localparam int            RW        = $clog2(8 * DEB_SCANS + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(8 * DEB_SCANS);
    localparam logic [RW-1:0] REP_NEXT  = RW'(2 * DEB_SCANS);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;
`endif

    always_comb begin
        prev_d   = prev_q;
        match_d  = match_q;
        rel_d    = rel_q;
        accept_o = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (flush_i) begin
            prev_d  = KEY_NONE;
            match_d = '0;
`ifdef KEY_REPEAT_EN
            rep_d   = '0;
`endif
        end else if (stb_i) begin
            prev_d = cand_i;
            if (cand_i == prev_q)
                match_d = (match_q == MATCH_FULL) ? match_q : match_q + 1'b1;
            else
                match_d = MW'(1);
            if (match_d == MATCH_FULL) begin
                if (cand_i == KEY_NONE) begin
                    rel_d = 1'b1;
                end else if (rel_q) begin
                    accept_o = 1'b1;
                    rel_d    = 1'b0;
                end
            end
`ifdef KEY_REPEAT_EN
            // Repeat counts only while the accepted key stays the stable sole key
            if (accept_o) begin
                rep_d       = '0;
                rep_first_d = 1'b1;
            end else if (!rel_q && cand_i != KEY_NONE && match_d == MATCH_FULL) begin
                rep_d = rep_q + 1'b1;
                if (rep_d == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
                    accept_o    = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end
            end else begin
                rep_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prev_q  <= KEY_NONE;
            match_q <= '0;
            rel_q   <= 1'b1;
        end else begin
            prev_q  <= prev_d;
            match_q <= match_d;
            rel_q   <= rel_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/matriz_teclado_scan_rx.sv
`default_nettype none
// ============================================================================
// matriz_teclado_scan_rx : column-scan keypad reader; one-hot active-low column
// drive, row sampling, debounce and valid/ack coordinate output.
// Optional auto-repeat via KEY_REPEAT_EN.  Rev 1.0
// ============================================================================
module matriz_teclado_scan_rx
    import matriz_teclado_pkg::*;
#(
    parameter int N_COL     = 8,
    parameter int N_LIN     = 7,
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               scan_en,
    output logic [N_COL-1:0]   k_col,
    input  logic [N_LIN-1:0]   k_line,
    output logic [2:0]         key_lin,
    output logic [2:0]         key_col,
    output logic               key_valid,
    input  logic               key_ack,
    output logic               key_ovf
);

    localparam int                 IDX_W    = $clog2(N_COL);
    localparam int                 DW       = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_COL - 1);
    localparam logic [DW-1:0]      DW_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [N_COL-1:0]   COL_ONE  = N_COL'(1);

    scan_state_t         state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DW-1:0]       dwell_q;
    logic [1:0]          hits_q;
    key_code_t           cand_q;
    logic [N_COL-1:0]    k_col_q;
    logic                valid_q;
    logic [2:0]          lin_q;
    logic [2:0]          col_q;
    logic                ovf_q;

    logic [1:0]          w_row_hits;
    logic [COORD_W-1:0]  w_row_first;
    key_code_t           w_cand;
    logic                w_stb;
    logic                w_flush;
    logic                w_accept;

    // Lowest active row wins the coordinate; hits saturate at 2 (ambiguous)
    always_comb begin
        w_row_hits  = 2'd0;
        w_row_first = '0;
        for (int i = N_LIN - 1; i >= 0; i--) begin
            if (!k_line[i]) begin
                w_row_first = COORD_W'(i);
                w_row_hits  = hit_sat_add(w_row_hits, 2'd1);
            end
        end
    end

    assign w_cand  = (hits_q == 2'd1) ? cand_q : KEY_NONE;
    assign w_stb   = (state_q == ST_EVAL) && scan_en;
    assign w_flush = (state_q != ST_IDLE) && !scan_en;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            hits_q  <= 2'd0;
            cand_q  <= KEY_NONE;
            k_col_q <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_en) begin
                        state_q <= ST_SCAN;
                        idx_q   <= '0;
                        dwell_q <= '0;
                        hits_q  <= 2'd0;
                        k_col_q <= ~COL_ONE;
                    end
                end
                ST_SCAN: begin
                    if (!scan_en) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        dwell_q <= '0;
                        hits_q  <= 2'd0;
                        k_col_q <= '1;
                    end else if (dwell_q == DW_LAST) begin
                        dwell_q <= '0;
                        hits_q  <= hit_sat_add(hits_q, w_row_hits);
                        if (hits_q == 2'd0 && w_row_hits != 2'd0)
                            cand_q <= '{lin: w_row_first, col: COORD_W'(idx_q)};
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_EVAL;
                            idx_q   <= '0;
                            k_col_q <= '1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            k_col_q <= ~(COL_ONE << (idx_q + 1'b1));
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    hits_q <= 2'd0;
                    if (scan_en) begin
                        state_q <= ST_SCAN;
                        k_col_q <= ~COL_ONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    k_col_q <= '1;
                end
            endcase
        end
    end

    matriz_teclado_debounce #(
        .DEB_SCANS (DEB_SCANS)
    ) u_debounce (
        .clk      (clk),
        .clr_n    (clr_n),
        .stb_i    (w_stb),
        .flush_i  (w_flush),
        .cand_i   (w_cand),
        .accept_o (w_accept)
    );

    // A same-cycle ack frees the holding register for the new coordinate
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            lin_q   <= 3'd0;
            col_q   <= 3'd0;
            ovf_q   <= 1'b0;
        end else if (w_accept) begin
            if (!valid_q || key_ack) begin
                valid_q <= 1'b1;
                lin_q   <= w_cand.lin;
                col_q   <= w_cand.col;
            end else begin
                ovf_q   <= 1'b1;
            end
        end else if (valid_q && key_ack) begin
            valid_q <= 1'b0;
        end
    end

    assign k_col     = k_col_q;
    assign key_valid = valid_q;
    assign key_lin   = lin_q;
    assign key_col   = col_q;
    assign key_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matriz_teclado_scan_rx.sv
`default_nettype none
// ============================================================================
// tb_matriz_teclado_scan_rx : directed bench with a key-matrix model
// Rev 1.0
// ============================================================================
module tb_matriz_teclado_scan_rx;

    localparam int N_COL    = 8;
    localparam int N_LIN    = 7;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int SCAN_CYC = N_COL * SCAN_DIV + 1;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              scan_en;
    logic              key_ack;
    logic [N_COL-1:0]  k_col;
    logic [N_LIN-1:0]  k_line;
    logic [2:0]        key_lin;
    logic [2:0]        key_col;
    logic              key_valid;
    logic              key_ovf;

    logic [N_COL-1:0]  pk [N_LIN];
    int                n_tot = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    // Pressed switch shorts its row to a driven (low) column
    always_comb begin
        k_line = '1;
        for (int r = 0; r < N_LIN; r++)
            k_line[r] = ~|(pk[r] & ~k_col);
    end

    matriz_teclado_scan_rx #(
        .N_COL     (N_COL),
        .N_LIN     (N_LIN),
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .scan_en   (scan_en),
        .k_col     (k_col),
        .k_line    (k_line),
        .key_lin   (key_lin),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_ovf   (key_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic v, input logic [2:0] l, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(key_valid), 32'(v));
        chk({tag, "_lin"},   32'(key_lin),   32'(l));
        chk({tag, "_col"},   32'(key_col),   32'(c));
    endtask

    task automatic release_all();
        for (int r = 0; r < N_LIN; r++) pk[r] = '0;
    endtask

    task automatic press(input int l, input int c);
        pk[l][c] = 1'b1;
    endtask

    task automatic scans(input int n);
        repeat (n * SCAN_CYC) @(posedge clk);
        #1;
    endtask

    // One-cycle ack at a scan start, then finish that scan to stay aligned
    task automatic do_ack(input string tag);
        key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
        chk({tag, "_ack"}, 32'(key_valid), 32'd0);
        repeat (SCAN_CYC - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n   = 1'b0;
        scan_en = 1'b0;
        key_ack = 1'b0;
        release_all();
        #12;
        chk("rst_kcol", 32'(k_col), 32'hFF);
        chk_key("rst", 1'b0, 3'd0, 3'd0);
        chk("rst_ovf", 32'(key_ovf), 32'd0);
        @(negedge clk) clr_n = 1'b1;

        @(posedge clk) #1 scan_en = 1'b1;
        @(posedge clk) #1;
        chk("start_kcol", 32'(k_col), 32'hFE);

        // Single clean press
        press(2, 5);
        scans(1);
        chk("t1_early", 32'(key_valid), 32'd0);
        scans(1);
        chk_key("t1", 1'b1, 3'd2, 3'd5);
        do_ack("t1");
        scans(1);
        chk("t1_hold", 32'(key_valid), 32'd0);
        release_all();
        scans(2);

        // Bouncing key
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) press(6, 1);
            else            release_all();
            scans(1);
            chk("t2_bounce", 32'(key_valid), 32'd0);
        end
        press(6, 1);
        scans(1);
        chk("t2_stable1", 32'(key_valid), 32'd0);
        scans(1);
        chk_key("t2", 1'b1, 3'd6, 3'd1);
        do_ack("t2");
        release_all();
        scans(2);

        // Two keys at once are ambiguous
        press(1, 0);
        press(4, 7);
        scans(1);
        chk("t3_two_a", 32'(key_valid), 32'd0);
        scans(1);
        chk("t3_two_b", 32'(key_valid), 32'd0);
        pk[4][7] = 1'b0;
        scans(1);
        chk("t3_one_a", 32'(key_valid), 32'd0);
        scans(1);
        chk_key("t3", 1'b1, 3'd1, 3'd0);
        do_ack("t3");
        release_all();
        scans(2);

        // Overflow: no ack between two accepts
        press(3, 3);
        scans(2);
        chk_key("t4_first", 1'b1, 3'd3, 3'd3);
        chk("t4_ovf0", 32'(key_ovf), 32'd0);
        release_all();
        scans(2);
        chk("t4_rel_ovf", 32'(key_ovf), 32'd0);
        press(3, 3);
        scans(2);
        chk_key("t4_second", 1'b1, 3'd3, 3'd3);
        chk("t4_ovf1", 32'(key_ovf), 32'd1);
        release_all();
        scans(2);
        press(5, 2);
        scans(1);
        chk("t4_kept_lin", 32'(key_lin), 32'd3);
        // Ack during the EVAL cycle that accepts 5/2
        repeat (SCAN_CYC - 1) @(posedge clk);
        #1 key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
        chk_key("t4_ackacc", 1'b1, 3'd5, 3'd2);
        chk("t4_ovf_keep", 32'(key_ovf), 32'd1);
        release_all();

        // Abort mid column 4, then restart
        repeat (17) @(posedge clk);
        #1;
        chk("t5_col4", 32'(k_col), 32'hEF);
        scan_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_abort", 32'(k_col), 32'hFF);
        chk_key("t5_retain", 1'b1, 3'd5, 3'd2);
        repeat (5) @(negedge clk);
        chk("t5_idle", 32'(k_col), 32'hFF);
        @(posedge clk) #1 scan_en = 1'b1;
        @(posedge clk) #1;
        chk("t5_restart", 32'(k_col), 32'hFE);
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        chk("t5_col1", 32'(k_col), 32'hFD);

        // Asynchronous reset mid-scan
        #3 clr_n = 1'b0;
        #1;
        chk("t6_kcol", 32'(k_col), 32'hFF);
        chk_key("t6", 1'b0, 3'd0, 3'd0);
        chk("t6_ovf", 32'(key_ovf), 32'd0);
        #20 clr_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
